decode_stage: RTL and testbench

Registered, handshaked instruction-decode stage for the 16-bit pipelined core. It sits between the fetch/IF-ID latch and the execute stage and turns the 5-bit opcode into the full control-signal bundle one cycle after acceptance. It supports valid/ready back-pressure, a halt drain state machine, an optional illegal-opcode trap and a saturating count of accepted instructions. It replaces the purely combinational decoder in the pipelined datapath.

---
 rtl/decode_stage_if.sv | 45 ++++
 rtl/decode_stage.sv | 147 ++++++++++++++
 tb/tb_decode_stage.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// decode_stage_if: handshake + decode-bundle bus around decode_stage.
//   Upstream side : in_valid, in_instr -> stage; in_ready <- stage.
//   Downstream    : out_valid, out_instr, control bundle -> execute;
//                   out_ready <- execute.
//   modport slave  : the decode stage's view.
//   modport master : the surrounding pipeline / testbench view.
interface decode_stage_if #(
  parameter int INSTR_W = 16
);
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [1:0]         regdst;
  logic               zero_ext;
  logic               regwrt;
  logic [1:0]         bsource;
  logic               branch;
  logic               alujmp;
  logic               memwrt;
  logic               immsrc;
  logic               asource;
  logic               regsrc;
  logic [2:0]         aluop;
  logic               inva;
  logic               invb;
  logic               halt;
  logic               illegal;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr, regdst, zero_ext, regwrt, bsource,
           branch, alujmp, memwrt, immsrc, asource, regsrc, aluop, inva, invb,
           halt, illegal
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, regdst, zero_ext, regwrt, bsource,
           branch, alujmp, memwrt, immsrc, asource, regsrc, aluop, inva, invb,
           halt, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered, valid/ready instruction-decode stage.
//   Decodes the 5-bit opcode (top bits of in_instr) into the control bundle
//   one cycle after acceptance, with a single-entry output register.
//   A HALT (or a trapped illegal opcode) drains the stage: RUN -> DRAIN ->
//   HALTED, leaving HALTED only through rst.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   ifc (slave)  : input handshake, output handshake and control bundle
//   halted       : stage is in HALTED
//   instr_count  : saturating count of accepted instructions
// Build option:
//   DECODE_ILLEGAL_TRAP_EN - when defined, unimplemented opcodes register
//   illegal=1 and drain the stage like HALT; otherwise they decode as NOP.
module decode_stage #(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  decode_stage_if.slave     ifc,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic [1:0] regdst;
    logic       zero_ext;
    logic       regwrt;
    logic [1:0] bsource;
    logic [2:0] aluop;
    logic       inva;
    logic       invb;
    logic       halt;
    logic       illegal;
  } ctrl_t;

  state_t             state_q, state_d;
  ctrl_t              dec, ctrl_q;
  logic               out_valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [4:0]         opcode;
  logic               accept, consume;

  assign opcode = ifc.in_instr[INSTR_W-1 -: 5];

  // in_ready depends only on state and the output register, never on in_valid.
  assign ifc.in_ready = (state_q == RUN) && (!out_valid_q || ifc.out_ready);
  assign accept       = ifc.in_valid && ifc.in_ready;
  assign consume      = out_valid_q && ifc.out_ready;

  always_comb begin
    dec = '0;
    case (opcode)
      5'b00000: dec.halt = 1'b1;
      5'b00001: ;
      5'b01000: begin
        dec.regdst = 2'b01; dec.bsource = 2'b01; dec.regwrt = 1'b1;
        dec.aluop  = 3'b100;
      end
      5'b01001: begin
        dec.regdst = 2'b01; dec.bsource = 2'b01; dec.regwrt = 1'b1;
        dec.aluop  = 3'b100; dec.inva = 1'b1;
      end
      5'b01010: begin
        dec.regdst = 2'b01; dec.bsource = 2'b01; dec.regwrt = 1'b1;
        dec.zero_ext = 1'b1; dec.aluop = 3'b111;
      end
      5'b01011: begin
        dec.regdst = 2'b01; dec.bsource = 2'b01; dec.regwrt = 1'b1;
        dec.zero_ext = 1'b1; dec.invb = 1'b1; dec.aluop = 3'b101;
      end
      5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
        // Rotate/shift immediates: ALU op is the low two opcode bits.
        dec.regdst = 2'b01; dec.bsource = 2'b01; dec.regwrt = 1'b1;
        dec.aluop  = {1'b0, opcode[1:0]};
      end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec.illegal = 1'b1;
`else
        dec = '0;
`endif
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state: after a stopping bundle is accepted no further accepts occur,
  // so the first consume seen in DRAIN is that bundle leaving.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && (dec.halt || dec.illegal)) state_d = DRAIN;
      DRAIN:   if (consume) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Output register: loads on accept, clears valid on a bare consume, and
  // otherwise holds (bundle fields keep their value while invalid).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      instr_q     <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      ctrl_q      <= dec;
      instr_q     <= ifc.in_instr;
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        instr_count <= '0;
    else if (accept && instr_count != {CNT_W{1'b1}}) instr_count <= instr_count + CNT_W'(1);
  end

  assign halted        = (state_q == HALTED);
  assign ifc.out_valid = out_valid_q;
  assign ifc.out_instr = instr_q;
  assign ifc.regdst    = ctrl_q.regdst;
  assign ifc.zero_ext  = ctrl_q.zero_ext;
  assign ifc.regwrt    = ctrl_q.regwrt;
  assign ifc.bsource   = ctrl_q.bsource;
  assign ifc.aluop     = ctrl_q.aluop;
  assign ifc.inva      = ctrl_q.inva;
  assign ifc.invb      = ctrl_q.invb;
  assign ifc.halt      = ctrl_q.halt;
  assign ifc.illegal   = ctrl_q.illegal;
  assign ifc.branch    = 1'b0;
  assign ifc.alujmp    = 1'b0;
  assign ifc.memwrt    = 1'b0;
  assign ifc.immsrc    = 1'b0;
  assign ifc.asource   = 1'b0;
  assign ifc.regsrc    = 1'b0;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: drivers push the expected bundle of every
// accepted instruction; a monitor pops and compares on each consume.
module tb_decode_stage;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if #(.INSTR_W(W)) ifc ();
  decode_stage_if #(.INSTR_W(W)) ifc2 ();
  logic        halted, halted2;
  logic [15:0] cnt;
  logic [3:0]  cnt2;

  decode_stage #(.INSTR_W(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ifc(ifc), .halted(halted), .instr_count(cnt));
  decode_stage #(.INSTR_W(W), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .ifc(ifc2), .halted(halted2), .instr_count(cnt2));

  typedef struct {
    logic [15:0] instr;
    logic [1:0]  regdst;
    logic        zext, regwrt;
    logic [1:0]  bsrc;
    logic [2:0]  aluop;
    logic        inva, invb, halt, illegal;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_cnt = 0;
  bit   rnd_mode = 0;

  // Reference decode: instruction families rather than a flat opcode table.
  function automatic exp_t model(input logic [15:0] instr);
    exp_t       e;
    logic [4:0] op;
    logic [2:0] imm_ops [4];
    imm_ops = '{3'b100, 3'b100, 3'b111, 3'b101};
    op = instr[15:11];
    e = '{default: 0};
    e.instr = instr;
    if (op == 5'd0) e.halt = 1'b1;
    else if (op == 5'd1) e.halt = 1'b0;
    else if (op[4:2] == 3'b010) begin
      e.regdst = 2'b01; e.bsrc = 2'b01; e.regwrt = 1'b1;
      e.aluop = imm_ops[op[1:0]];
      e.inva  = (op[1:0] == 2'd1);
      e.zext  = op[1];
      e.invb  = (op[1:0] == 2'd3);
    end else if (op[4:2] == 3'b101) begin
      e.regdst = 2'b01; e.bsrc = 2'b01; e.regwrt = 1'b1;
      e.aluop = {1'b0, op[1:0]};
    end else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      e.illegal = 1'b1;
`endif
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every consume pops one expected bundle.
  always @(negedge clk) begin
    if (!rst && ifc.out_valid && ifc.out_ready) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_bundle: got instr %h expected none", ifc.out_instr);
      end else begin
        me = q.pop_front();
        chk("out_instr", 32'(ifc.out_instr), 32'(me.instr));
        chk("bundle",
            32'({ifc.regdst, ifc.zero_ext, ifc.regwrt, ifc.bsource, ifc.aluop, ifc.inva,
                 ifc.invb, ifc.halt, ifc.illegal, ifc.branch, ifc.alujmp, ifc.memwrt,
                 ifc.immsrc, ifc.asource, ifc.regsrc}),
            32'({me.regdst, me.zext, me.regwrt, me.bsrc, me.aluop, me.inva, me.invb,
                 me.halt, me.illegal, 6'b0}));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) ifc.out_ready = ($urandom_range(3) != 0);
  endtask

  // Present instr until accepted; called and returns at posedge+1.
  task automatic send(input logic [15:0] instr);
    bit ok;
    ok = 0;
    ifc.in_valid = 1'b1;
    ifc.in_instr = instr;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (ifc.in_ready) begin
        tick();
        q.push_back(model(instr));
        model_cnt++;
        ok = 1;
      end else tick();
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no accept expected accept of %h", instr);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    q.delete();
    model_cnt = 0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(ifc.in_ready), 32'd1);
    tick();
  endtask

  // Keep offering ADDI while the stage drains; it must never be taken.
  task automatic wait_halt();
    int n;
    n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_instr = 16'h4000;
    @(negedge clk);
    while (!halted && n < 300) begin
      chk("in_ready_drain", 32'(ifc.in_ready), 32'd0);
      tick();
      n++;
      @(negedge clk);
    end
    chk("halted", 32'(halted), 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("count", 32'(cnt), 32'(model_cnt));
    chk("in_ready_halted", 32'(ifc.in_ready), 32'd0);
    tick();
    ifc.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  impl_ops [9];
    logic [4:0]  bad_ops [4];
    logic [15:0] instr;
    bit          stop;
    impl_ops = '{5'd1, 5'd8, 5'd9, 5'd10, 5'd11, 5'd20, 5'd21, 5'd22, 5'd23};
    bad_ops  = '{5'b11111, 5'b00010, 5'b11000, 5'b01100};
    ifc.in_valid = 1'b0; ifc.in_instr = '0; ifc.out_ready = 1'b1;
    ifc2.in_valid = 1'b0; ifc2.in_instr = 16'h0800; ifc2.out_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_ctrl", 32'({ifc.regwrt, ifc.aluop, ifc.halt, ifc.illegal}), 32'd0);
    chk("rst_out_instr", 32'(ifc.out_instr), 32'd0);

    // Saturating counter on the CNT_W=4 instance
    tick();
    rst2 = 1'b0;
    ifc2.in_valid = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1 || k == 14 || k == 15 || k == 20)
        chk("sat_count", 32'(cnt2), (k > 15) ? 32'd15 : 32'(k));
    end
    ifc2.in_valid = 1'b0;

    // ADDI, XORI, RORI back to back
    do_reset();
    send(16'h4000); send(16'h5000); send(16'hB000);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("count3", 32'(cnt), 32'd3);
    tick();
    @(negedge clk);
    chk("valid_drop", 32'(ifc.out_valid), 32'd0);
    chk("hold_aluop", 32'(ifc.aluop), 32'd2);
    chk("queue_empty", 32'(q.size()), 32'd0);
    tick();

    // SUBI stalled three cycles, then consume and accept in the same cycle
    ifc.out_ready = 1'b0;
    send(16'h4800);
    ifc.in_valid = 1'b1; ifc.in_instr = 16'h4000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(ifc.out_valid), 32'd1);
      chk("stall_bundle", 32'({ifc.inva, ifc.aluop}), 32'({1'b1, 3'b100}));
      chk("stall_instr", 32'(ifc.out_instr), 32'h4800);
      chk("stall_ready", 32'(ifc.in_ready), 32'd0);
      tick();
    end
    ifc.out_ready = 1'b1;
    send(16'h4000);
    ifc.in_valid = 1'b0;
    tick(); tick();

    // NOP, HALT, then ADDI must never enter
    do_reset();
    send(16'h0800); send(16'h0000);
    ifc.in_valid = 1'b1; ifc.in_instr = 16'h4000;
    @(negedge clk);
    chk("halt_pending_halted", 32'(halted), 32'd0);
    chk("halt_pending_ready", 32'(ifc.in_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("halted_after_consume", 32'(halted), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("halted_ready", 32'(ifc.in_ready), 32'd0);
    end
    chk("halt_count", 32'(cnt), 32'd2);
    chk("halt_queue", 32'(q.size()), 32'd0);
    tick();
    ifc.in_valid = 1'b0;

    // Unimplemented opcode 11111
    do_reset();
    send(16'hF800);
`ifdef DECODE_ILLEGAL_TRAP_EN
    wait_halt();
`else
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("illegal_off", 32'(ifc.illegal), 32'd0);
    tick();
    @(negedge clk);
    chk("illegal_running", 32'({halted, ifc.in_ready}), 32'b01);
    tick();
    send(16'h4000);
    ifc.in_valid = 1'b0;
    tick();
    chk("illegal_count", 32'(cnt), 32'd2);
`endif

    // Reset in DRAIN with a stalled HALT
    do_reset();
    ifc.out_ready = 1'b0;
    send(16'h0000);
    ifc.in_valid = 1'b1; ifc.in_instr = 16'h4000;
    @(negedge clk);
    chk("drain_ready", 32'(ifc.in_ready), 32'd0);
    chk("drain_valid", 32'(ifc.out_valid), 32'd1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(ifc.out_valid), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
    chk("mid_rst_count", 32'(cnt), 32'd0);
    chk("mid_rst_halt", 32'(ifc.halt), 32'd0);
    q.delete(); model_cnt = 0;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_drain_rst", 32'(ifc.in_ready), 32'd1);
    tick();

    // Randomized sessions with random back-pressure and idle gaps
    for (int s = 0; s < 6; s++) begin
      do_reset();
      rnd_mode = 1;
      stop = 0;
      for (int i = 0; i < 50 && !stop; i++) begin
        int r;
        r = $urandom_range(99);
        if (r < 3)      instr = {5'd0, 11'($urandom)};
        else if (r < 8) instr = {bad_ops[$urandom_range(3)], 11'($urandom)};
        else            instr = {impl_ops[$urandom_range(8)], 11'($urandom)};
        send(instr);
        if (model(instr).halt || model(instr).illegal) stop = 1;
        else if ($urandom_range(3) == 0) begin
          ifc.in_valid = 1'b0;
          tick();
        end
      end
      if (!stop) send(16'h0000);
      wait_halt();
      rnd_mode = 0;
      ifc.out_ready = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
